// File: rtl/hgcal_fc_pkg.sv
// ---------------------------------------------------------------------------
// hgcal_fc_pkg
//   Shared definitions for the HGCAL fast-control receive path: the
//   alignment FSM state encoding, the default idle/sync word and the
//   fast-command codes that the downstream decoder also uses.
// ---------------------------------------------------------------------------
package hgcal_fc_pkg;

    // LOCKED is the only state with bit 1 set, so "locked" is a flop bit.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } fc_state_e;

    localparam logic [7:0] FC_SYNC_WORD = 8'hAC;

    // Fast-command codes shared with the fast-command decoder.
    localparam logic [7:0] FC_CMD_IDLE    = FC_SYNC_WORD;
    localparam logic [7:0] FC_CMD_BCR     = 8'h2D;
    localparam logic [7:0] FC_CMD_L1A     = 8'h33;
    localparam logic [7:0] FC_CMD_OCR     = 8'h4B;
    localparam logic [7:0] FC_CMD_CALIB   = 8'h55;
    localparam logic [7:0] FC_CMD_LINKRST = 8'h69;

endpackage

// File: rtl/hgcal_fc_align_fsm.sv
// ---------------------------------------------------------------------------
// hgcal_fc_align_fsm
//   Word-alignment state machine for the fast-control link. Owns the bit
//   phase counter (word boundary when bit_cnt==7), the lock confirmation
//   counter and the gap counter that drops lock when sync words stop
//   arriving on the locked phase.
// Ports
//   clk320        in   bit clock
//   reset_n       in   asynchronous active-low reset
//   i_nxt         in   8-bit window ending with the bit sampled this cycle
//   o_state       out  current state (HUNT / CONFIRM / LOCKED)
//   o_word_accept out  this edge closes a locked word that must be output
//   o_gap_expire  out  this edge closes the word that exhausts the gap budget
// ---------------------------------------------------------------------------
module hgcal_fc_align_fsm
    import hgcal_fc_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = FC_SYNC_WORD,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 64
) (
    input  logic       clk320,
    input  logic       reset_n,
    input  logic [7:0] i_nxt,
    output fc_state_e  o_state,
    output logic       o_word_accept,
    output logic       o_gap_expire
);

    localparam int              GW         = $clog2(MAX_GAP + 1);
    localparam logic [GW-1:0]   GAP_LAST   = GW'(MAX_GAP - 1);
    localparam logic [3:0]      MATCH_LAST = 4'(LOCK_COUNT - 1);

    fc_state_e       r_state,     w_state_nxt;
    logic [2:0]      r_bit_cnt,   w_bit_nxt;
    logic [3:0]      r_match_cnt, w_match_nxt;
    logic [GW-1:0]   r_gap_cnt,   w_gap_nxt;
    logic            w_is_sync;
    logic            w_boundary;
    logic            w_accept;
    logic            w_expire;

    assign w_is_sync  = (i_nxt == SYNC_WORD);
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt + 3'd1;
        w_match_nxt = r_match_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_accept    = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            HUNT: begin
                // A match anywhere defines the phase: this edge is a boundary.
                if (w_is_sync) begin
                    w_bit_nxt   = 3'd0;
                    w_match_nxt = 4'd1;
                    if (LOCK_COUNT == 1) begin
                        w_state_nxt = LOCKED;
                        w_gap_nxt   = '0;
                    end else begin
                        w_state_nxt = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (w_boundary) begin
                    if (w_is_sync) begin
                        if (r_match_cnt == MATCH_LAST) begin
                            w_state_nxt = LOCKED;
                            w_match_nxt = 4'd0;
                            w_gap_nxt   = '0;
                        end else begin
                            w_match_nxt = r_match_cnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = HUNT;
                        w_match_nxt = 4'd0;
                    end
                end
            end
            LOCKED: begin
                // Off-phase sync words are ignored: only boundaries matter.
                if (w_boundary) begin
                    if (w_is_sync) begin
                        w_gap_nxt = '0;
                        w_accept  = 1'b1;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        w_expire    = 1'b1;
                        w_state_nxt = HUNT;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap_cnt + 1'b1;
                        w_accept  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_match_nxt = 4'd0;
                w_gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk320 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= HUNT;
            r_bit_cnt   <= 3'd0;
            r_match_cnt <= 4'd0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_match_cnt <= w_match_nxt;
            r_gap_cnt   <= w_gap_nxt;
        end
    end

    assign o_state       = r_state;
    assign o_word_accept = w_accept;
    assign o_gap_expire  = w_expire;

endmodule

// File: rtl/hgcal_fc_deserializer.sv
// ---------------------------------------------------------------------------
// hgcal_fc_deserializer
//   Receive end of the HGCAL fast-control link. Shifts in the 320 Mb/s
//   stream MSB first, lets hgcal_fc_align_fsm find and hold word alignment
//   on the idle/sync word, and presents one word per 8 bit clocks with a
//   one-cycle valid strobe while locked.
//   Optional feature macro: HGCAL_FC_LOSS_CNT_EN enables the saturating
//   lock-loss counter; without it lock_loss_count is tied to zero.
// Ports
//   clk320          in   320 MHz bit clock, sole clock domain
//   reset_n         in   asynchronous active-low reset
//   fc_serial_in    in   serial bit, synchronous to clk320
//   fc_word         out  last received word, bit 7 = first bit on the line
//   fc_word_valid   out  1-cycle pulse when fc_word updates (LOCKED only)
//   locked          out  high while in LOCKED
//   sync_error      out  1-cycle pulse on LOCKED->HUNT
//   lock_loss_count out  saturating count of lock losses
// ---------------------------------------------------------------------------
module hgcal_fc_deserializer
    import hgcal_fc_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD  = FC_SYNC_WORD,
    parameter int         LOCK_COUNT = 4,
    parameter int         MAX_GAP    = 64
) (
    input  logic        clk320,
    input  logic        reset_n,
    input  logic        fc_serial_in,
    output logic [7:0]  fc_word,
    output logic        fc_word_valid,
    output logic        locked,
    output logic        sync_error,
    output logic [15:0] lock_loss_count
);

    // Only the 7 most recent bits are needed to form the next window.
    logic [6:0] r_sreg;
    logic [7:0] w_nxt;
    logic [7:0] r_fc_word;
    logic       r_valid;
    logic       r_sync_error;
    fc_state_e  w_state;
    logic       w_accept;
    logic       w_expire;

    assign w_nxt = {r_sreg, fc_serial_in};

    hgcal_fc_align_fsm #(
        .SYNC_WORD  (SYNC_WORD),
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_GAP    (MAX_GAP)
    ) u_align_fsm (
        .clk320        (clk320),
        .reset_n       (reset_n),
        .i_nxt         (w_nxt),
        .o_state       (w_state),
        .o_word_accept (w_accept),
        .o_gap_expire  (w_expire)
    );

    always_ff @(posedge clk320 or negedge reset_n) begin
        if (!reset_n) begin
            r_sreg       <= 7'd0;
            r_fc_word    <= 8'd0;
            r_valid      <= 1'b0;
            r_sync_error <= 1'b0;
        end else begin
            r_sreg       <= w_nxt[6:0];
            r_valid      <= w_accept;
            r_sync_error <= w_expire;
            if (w_accept) begin
                r_fc_word <= w_nxt;
            end
        end
    end

    assign fc_word       = r_fc_word;
    assign fc_word_valid = r_valid;
    assign sync_error    = r_sync_error;
    // State is a register and LOCKED is a single encoding bit.
    assign locked        = (w_state == LOCKED);

`ifdef HGCAL_FC_LOSS_CNT_EN
    logic [15:0] r_loss_cnt;

    // Counts on the same edge that raises sync_error so both appear together.
    always_ff @(posedge clk320 or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= 16'h0000;
        end else if (w_expire && (r_loss_cnt != 16'hFFFF)) begin
            r_loss_cnt <= r_loss_cnt + 16'h0001;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`else
    assign lock_loss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hgcal_fc_deserializer.sv
`timescale 1ns/1ps
module tb_hgcal_fc_deserializer;

  localparam logic [7:0] SYNC = 8'hAC;

  // ---------------- clock / reset ----------------
  logic        clk320 = 1'b0;
  logic        reset_n;
  logic        fc_serial_in;
  logic [7:0]  fc_word;
  logic        fc_word_valid;
  logic        locked;
  logic        sync_error;
  logic [15:0] lock_loss_count;

  always #2 clk320 = ~clk320;

  int cyc = 0;
  always @(posedge clk320) cyc <= cyc + 1;

  hgcal_fc_deserializer dut (
    .clk320          (clk320),
    .reset_n         (reset_n),
    .fc_serial_in    (fc_serial_in),
    .fc_word         (fc_word),
    .fc_word_valid   (fc_word_valid),
    .locked          (locked),
    .sync_error      (sync_error),
    .lock_loss_count (lock_loss_count)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         n_checks = 0;
  int         n_errs = 0;
  int         n_serr = 0;
  int         exp_loss = 0;
  logic [7:0] mon_w;
  int         mon_c;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive at a negedge, return at the following negedge so outputs caused
  // by this bit can be sampled immediately.
  task automatic send_bit(input logic b);
    fc_serial_in = b;
    @(posedge clk320);
    @(negedge clk320);
  endtask

  task automatic push_exp(input logic [7:0] w);
    exp_q.push_back(w);
    exp_cyc_q.push_back(cyc + 1);
  endtask

  task automatic send_word(input logic [7:0] w, input bit push);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && push) push_exp(w);
      send_bit(w[i]);
    end
  endtask

  task automatic lock_up(input int offset);
    for (int i = 0; i < offset; i++) send_bit(1'b0);
    for (int k = 0; k < 4; k++) begin
      send_word(SYNC, 1'b0);
      if (k == 2) check_eq("locked_before_4th", locked, 1'b0);
      if (k == 3) check_eq("locked_after_4th", locked, 1'b1);
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk320) begin
    if (reset_n) begin
      if (sync_error) n_serr++;
      if (fc_word_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("valid_without_expected_word", exp_q.size(), 1);
        end else begin
          mon_w = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check_eq("word", fc_word, mon_w);
          check_eq("valid_cycle", cyc, mon_c);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int serr_before;

  initial begin
    reset_n = 1'b0;
    fc_serial_in = 1'b0;
    #1;
    check_eq("rst_fc_word", fc_word, 8'h00);
    check_eq("rst_valid", fc_word_valid, 1'b0);
    check_eq("rst_locked", locked, 1'b0);
    check_eq("rst_sync_error", sync_error, 1'b0);
    check_eq("rst_loss_cnt", lock_loss_count, 16'h0000);
    repeat (3) @(negedge clk320);
    reset_n = 1'b1;

    // 1: lock on idles at an arbitrary offset; first output is the next idle
    lock_up($urandom_range(0, 7));
    send_word(SYNC, 1'b1);

    // 2: data words between idles
    send_word(8'h2D, 1'b1);
    check_eq("word_2d", fc_word, 8'h2D);
    check_eq("valid_2d", fc_word_valid, 1'b1);
    send_bit(1'b1);
    check_eq("valid_falls", fc_word_valid, 1'b0);
    check_eq("word_holds", fc_word, 8'h2D);
    for (int i = 6; i >= 0; i--) begin
      if (i == 0) push_exp(SYNC);
      send_bit(SYNC[i]);
    end
    for (int k = 0; k < 4; k++) send_word(8'($urandom_range(0, 255)), 1'b1);
    send_word(SYNC, 1'b1);

    // 4: 64 non-sync words drop lock; the 64th is not output
    serr_before = n_serr;
    for (int k = 0; k < 64; k++) begin
      send_word(8'h00, k < 63);
      if (k == 62) check_eq("locked_before_expiry", locked, 1'b1);
    end
`ifdef HGCAL_FC_LOSS_CNT_EN
    exp_loss++;
`endif
    check_eq("gap_sync_error", sync_error, 1'b1);
    check_eq("gap_locked_low", locked, 1'b0);
    check_eq("gap_loss_cnt", lock_loss_count, exp_loss);
    send_bit(1'b0);
    check_eq("sync_error_1cycle", sync_error, 1'b0);
    check_eq("sync_error_once", n_serr - serr_before, 1);
    check_eq("word_held_after_loss", fc_word, 8'h00);

    // 3: broken confirmation returns to HUNT; 4 fresh syncs needed
    send_word(SYNC, 1'b0);
    send_word(SYNC, 1'b0);
    send_word(8'h00, 1'b0);
    check_eq("confirm_abort_locked", locked, 1'b0);
    lock_up(0);
    send_word(SYNC, 1'b1);
    send_word(8'h2D, 1'b1);
    send_word(SYNC, 1'b1);

    // 5: 3-bit phase slip; off-phase idles never realign before expiry
    serr_before = n_serr;
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    for (int k = 0; k < 64; k++) begin
      for (int i = 7; i >= 0; i--) begin
        if (i == 3 && k < 63) push_exp((k == 0) ? 8'h15 : 8'h95);
        send_bit(SYNC[i]);
        if (i == 3 && k == 62) check_eq("slip_still_locked", locked, 1'b1);
        if (i == 3 && k == 63) begin
`ifdef HGCAL_FC_LOSS_CNT_EN
          exp_loss++;
`endif
          check_eq("slip_sync_error", sync_error, 1'b1);
          check_eq("slip_locked_low", locked, 1'b0);
          check_eq("slip_loss_cnt", lock_loss_count, exp_loss);
        end
      end
    end
    check_eq("slip_one_error", n_serr - serr_before, 1);
    // the idle just completed was the first of the new phase
    for (int k = 0; k < 3; k++) begin
      send_word(SYNC, 1'b0);
      if (k == 1) check_eq("relock_pending", locked, 1'b0);
      if (k == 2) check_eq("relock_new_phase", locked, 1'b1);
    end
    send_word(8'h33, 1'b1);
    send_word(SYNC, 1'b1);

    // 6: reset mid-word while locked
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset_n = 1'b0;
    exp_loss = 0;
    #1;
    check_eq("midrst_fc_word", fc_word, 8'h00);
    check_eq("midrst_valid", fc_word_valid, 1'b0);
    check_eq("midrst_locked", locked, 1'b0);
    check_eq("midrst_sync_error", sync_error, 1'b0);
    check_eq("midrst_loss_cnt", lock_loss_count, 16'h0000);
    repeat (2) @(negedge clk320);
    reset_n = 1'b1;
    lock_up($urandom_range(0, 7));
    send_word(8'h5A, 1'b1);
    send_word(SYNC, 1'b1);
    repeat (4) send_bit(1'b0);

    // ---------------- final report ----------------
    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
